// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: CPU has fixed priority, and the loader is forced a
// grant after STARVE_LIMIT consecutive CPU grants made while it was waiting.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  ldr_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            dbg_state,
  output logic                  dbg_grant,
  output logic [CNT_W-1:0]      dbg_starve_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_LDR = 1'b1;

  logic [1:0]            state;
  logic                  grant;
  logic [CNT_W-1:0]      starve_cnt;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] ldr_rdata_q;
  logic                  starved;
  logic                  ldr_wins;

  // Handshake: a requester raises req with stable we/addr/wdata and holds them until it
  // sees its one-cycle ack; req is only sampled in IDLE, so a transaction once granted
  // always runs IDLE -> ACCESS -> RESP and acks even if req is dropped meanwhile.
  assign starved  = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign ldr_wins = ldr_req & (~cpu_req | starved);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= GRANT_CPU;
      starve_cnt  <= '0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req | ldr_req) begin
            state <= ACCESS;
            if (ldr_wins) begin
              grant      <= GRANT_LDR;
              we_r       <= ldr_we;
              addr_r     <= ldr_addr;
              wdata_r    <= ldr_wdata;
              starve_cnt <= '0;
            end else begin
              grant   <= GRANT_CPU;
              we_r    <= cpu_we;
              addr_r  <= cpu_addr;
              wdata_r <= cpu_wdata;
              // Only grants taken while the loader is waiting count toward starvation.
              if (ldr_req && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end
          end
        end
        ACCESS: state <= RESP;
        RESP: begin
          state <= IDLE;
          if (!we_r) begin
            if (grant == GRANT_CPU) begin
              cpu_rdata_q <= mem_rdata;
            end else begin
              ldr_rdata_q <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

  assign cpu_ack   = (state == RESP) && (grant == GRANT_CPU);
  assign ldr_ack   = (state == RESP) && (grant == GRANT_LDR);
  assign cpu_stall = cpu_req & ~cpu_ack;

  // Read data is presented straight from memory during ack, then held from the capture.
  assign cpu_rdata = (cpu_ack && !we_r) ? mem_rdata : cpu_rdata_q;
  assign ldr_rdata = (ldr_ack && !we_r) ? mem_rdata : ldr_rdata_q;

  assign dbg_state      = state;
  assign dbg_grant      = grant;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: cycle-by-cycle vector table for basic traffic, then hand
// sequences for starvation, reset mid-access and an early-dropped request.
module tb_dmem_arbiter;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [31:0] ldr_addr = '0, ldr_wdata = '0;
  logic [31:0] ldr_rdata;
  logic        ldr_ack;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  dbg_state;
  logic        dbg_grant;
  logic [2:0]  dbg_starve_cnt;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_grant(dbg_grant), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model: unwritten words read as 0xA000_0000 + word index
  logic [31:0] mem_arr [0:63];
  bit   [63:0] written = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_arr[mem_addr[7:2]] <= mem_wdata;
        written[mem_addr[7:2]] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr[7:2]] ? mem_arr[mem_addr[7:2]]
                                            : (32'hA000_0000 + {26'd0, mem_addr[7:2]});
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       creq;
    logic       cwe;
    logic [7:0] caddr;
    logic [7:0] cwd;
    logic       lreq;
    logic       lwe;
    logic [7:0] laddr;
    logic [7:0] lwd;
    logic       men;
    logic       mwe;
    logic [7:0] maddr;
    logic [7:0] mwd;
    logic       cack;
    logic       lack;
    logic       stall;
    logic [1:0] st;
    logic [31:0] crd;
    logic [31:0] lrd;
  } vec_t;

  vec_t vecs [18];

  // driver
  task automatic drive(input vec_t v);
    reset     = v.rst;
    cpu_req   = v.creq;
    cpu_we    = v.cwe;
    cpu_addr  = {24'd0, v.caddr};
    cpu_wdata = {24'd0, v.cwd};
    ldr_req   = v.lreq;
    ldr_we    = v.lwe;
    ldr_addr  = {24'd0, v.laddr};
    ldr_wdata = {24'd0, v.lwd};
  endtask

  localparam logic [31:0] A2 = 32'hA000_0002;

  logic exp_q [$];
  int   exp_cnt [6] = '{1, 2, 3, 4, 0, 1};

  initial begin
    //            rst   creq  cwe   caddr   cwd    lreq  lwe   laddr    lwd     men   mwe   maddr    mwd     cack  lack  stall st         crd     lrd
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'd8,   8'd0,  1'b1, 1'b1, 8'd100, 8'd25,  1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, ST_IDLE,   32'd0,  32'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'd8,   8'd0,  1'b1, 1'b1, 8'd100, 8'd25,  1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, ST_IDLE,   32'd0,  32'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'd8,   8'd0,  1'b1, 1'b1, 8'd100, 8'd25,  1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, ST_IDLE,   32'd0,  32'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'd8,   8'd0,  1'b1, 1'b1, 8'd100, 8'd25,  1'b1, 1'b0, 8'd8,   8'd0,   1'b0, 1'b0, 1'b1, ST_ACCESS, 32'd0,  32'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'd8,   8'd0,  1'b1, 1'b1, 8'd100, 8'd25,  1'b0, 1'b0, 8'd8,   8'd0,   1'b1, 1'b0, 1'b0, ST_RESP,   A2,     32'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  1'b1, 1'b1, 8'd100, 8'd25,  1'b0, 1'b0, 8'd8,   8'd0,   1'b0, 1'b0, 1'b0, ST_IDLE,   A2,     32'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  1'b1, 1'b1, 8'd100, 8'd25,  1'b1, 1'b1, 8'd100, 8'd25,  1'b0, 1'b0, 1'b0, ST_ACCESS, A2,     32'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  1'b1, 1'b1, 8'd100, 8'd25,  1'b0, 1'b0, 8'd100, 8'd25,  1'b0, 1'b1, 1'b0, ST_RESP,   A2,     32'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'd96,  8'd7,  1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 8'd100, 8'd25,  1'b0, 1'b0, 1'b1, ST_IDLE,   A2,     32'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'd96,  8'd7,  1'b0, 1'b0, 8'd0,   8'd0,   1'b1, 1'b1, 8'd96,  8'd7,   1'b0, 1'b0, 1'b1, ST_ACCESS, A2,     32'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'd96,  8'd7,  1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 8'd96,  8'd7,   1'b1, 1'b0, 1'b0, ST_RESP,   A2,     32'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'd96,  8'd0,  1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 8'd96,  8'd7,   1'b0, 1'b0, 1'b1, ST_IDLE,   A2,     32'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'd96,  8'd0,  1'b0, 1'b0, 8'd0,   8'd0,   1'b1, 1'b0, 8'd96,  8'd0,   1'b0, 1'b0, 1'b1, ST_ACCESS, A2,     32'd0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'd96,  8'd0,  1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 8'd96,  8'd0,   1'b1, 1'b0, 1'b0, ST_RESP,   32'd7,  32'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  1'b1, 1'b0, 8'd100, 8'd0,   1'b0, 1'b0, 8'd96,  8'd0,   1'b0, 1'b0, 1'b0, ST_IDLE,   32'd7,  32'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  1'b1, 1'b0, 8'd100, 8'd0,   1'b1, 1'b0, 8'd100, 8'd0,   1'b0, 1'b0, 1'b0, ST_ACCESS, 32'd7,  32'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  1'b1, 1'b0, 8'd100, 8'd0,   1'b0, 1'b0, 8'd100, 8'd0,   1'b0, 1'b1, 1'b0, ST_RESP,   32'd7,  32'd25};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 8'd100, 8'd0,   1'b0, 1'b0, 1'b0, ST_IDLE,   32'd7,  32'd25};

    // reset, CPU load vs loader write, store/load round trip, loader alone
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d mem_en", i),    mem_en,    vecs[i].men);
      check($sformatf("v%0d mem_we", i),    mem_we,    vecs[i].mwe);
      check($sformatf("v%0d mem_addr", i),  mem_addr,  {24'd0, vecs[i].maddr});
      check($sformatf("v%0d mem_wdata", i), mem_wdata, {24'd0, vecs[i].mwd});
      check($sformatf("v%0d cpu_ack", i),   cpu_ack,   vecs[i].cack);
      check($sformatf("v%0d ldr_ack", i),   ldr_ack,   vecs[i].lack);
      check($sformatf("v%0d cpu_stall", i), cpu_stall, vecs[i].stall);
      check($sformatf("v%0d state", i),     dbg_state, vecs[i].st);
      check($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].crd);
      check($sformatf("v%0d ldr_rdata", i), ldr_rdata, vecs[i].lrd);
    end
    check("pre_starve cnt", dbg_starve_cnt, 0);

    // starvation: both requesters held; expected grant order C C C C L C (1 = CPU)
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd16;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'd20;
    for (int t = 0; t < 6; t++) begin
      logic got;
      logic exp_cpu;
      got = 1'b0;
      exp_cpu = exp_q.pop_front();
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        #1;
        if (cpu_ack || ldr_ack) begin
          got = 1'b1;
          break;
        end
      end
      check($sformatf("starve%0d ack_seen", t), got, 1'b1);
      check($sformatf("starve%0d cpu_ack", t), cpu_ack, exp_cpu);
      check($sformatf("starve%0d ldr_ack", t), ldr_ack, !exp_cpu);
      check($sformatf("starve%0d cnt", t), dbg_starve_cnt, exp_cnt[t]);
      if (exp_cpu) check($sformatf("starve%0d cpu_rdata", t), cpu_rdata, 32'hA000_0004);
      else         check($sformatf("starve%0d ldr_rdata", t), ldr_rdata, 32'hA000_0005);
    end
    cpu_req = 1'b0; ldr_req = 1'b0;

    // reset during ACCESS of a CPU load, then re-request
    @(negedge clk); #1;
    check("rst5 idle", dbg_state, ST_IDLE);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd32;
    @(negedge clk); #1;
    check("rst5 access mem_en", mem_en, 1'b1);
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    check("rst5 after state", dbg_state, ST_IDLE);
    check("rst5 after cpu_ack", cpu_ack, 1'b0);
    check("rst5 after mem_en", mem_en, 1'b0);
    check("rst5 after cpu_rdata", cpu_rdata, 32'd0);
    check("rst5 after cnt", dbg_starve_cnt, 0);
    check("rst5 after grant", dbg_grant, 1'b0);
    @(negedge clk); #1;
    check("rst5 re access", dbg_state, ST_ACCESS);
    check("rst5 re no ack", cpu_ack, 1'b0);
    @(negedge clk); #1;
    check("rst5 re cpu_ack", cpu_ack, 1'b1);
    check("rst5 re cpu_rdata", cpu_rdata, 32'hA000_0008);
    cpu_req = 1'b0;

    // cpu_req dropped during ACCESS: transaction still completes once
    @(negedge clk); #1;
    check("drop6 idle", dbg_state, ST_IDLE);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd36;
    @(negedge clk); #1;
    check("drop6 mem_en", mem_en, 1'b1);
    check("drop6 mem_addr", mem_addr, 32'd36);
    cpu_req = 1'b0;
    @(negedge clk); #1;
    check("drop6 cpu_ack", cpu_ack, 1'b1);
    check("drop6 stall", cpu_stall, 1'b0);
    check("drop6 cpu_rdata", cpu_rdata, 32'hA000_0009);
    @(negedge clk); #1;
    check("drop6 ack_once", cpu_ack, 1'b0);
    check("drop6 back_idle", dbg_state, ST_IDLE);
    @(negedge clk); #1;
    check("drop6 stay_idle", dbg_state, ST_IDLE);
    check("drop6 no_mem_en", mem_en, 1'b0);
    check("drop6 cpu_rdata_held", cpu_rdata, 32'hA000_0009);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
